// File: rtl/wb_trace_pkg.sv
// Shared types for the write-back trace buffer: FSM encoding and FIFO entry layout.
package wb_trace_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned ENTRY_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] data;
   } entry_t;

endpackage

// File: rtl/wb_trace_fifo.sv
// Synchronous FIFO with registered read port; a push while full is accepted only alongside a pop.
module wb_trace_fifo
   import wb_trace_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  entry_t        push_data,
   input  logic          pop_req,
   output logic          push_ok_c,
   output logic [AW:0]   count_next_c,
   output logic          rd_valid,
   output entry_t        rd_data,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   localparam int unsigned CW = AW + 1;

   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            full_q, full_d;
   logic            empty_q, empty_d;
   logic            rd_valid_q, rd_valid_d;
   entry_t          rd_data_q, rd_data_d;
   logic            pop_c;

   always_comb begin
      pop_c      = pop_req && !empty_q;
      push_ok_c  = push && (!full_q || pop_c);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_valid_d = pop_c;
      rd_data_d  = rd_data_q;
      if (push_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_c) begin
         rd_ptr_d  = rd_ptr_q + AW'(1);
         rd_data_d = mem_q[rd_ptr_q];
      end
      case ({push_ok_c, pop_c})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      full_d       = (count_d == CW'(DEPTH));
      empty_d      = (count_d == '0);
      count_next_c = count_d;
   end

   // Storage has no reset; contents are meaningless until written.
   always_ff @(posedge clk) begin
      if (push_ok_c) mem_q[wr_ptr_q] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign count    = count_q;
   assign full     = full_q;
   assign empty    = empty_q;

endmodule

// File: rtl/wb_trace_buffer.sv
// Write-back trace capture: arms on a trigger PC, then logs (PC, data) pairs into a drainable FIFO.
module wb_trace_buffer
   import wb_trace_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [XLEN-1:0]  PC_Counter,
   input  logic [XLEN-1:0]  Reg_Write,
   input  logic             RegWrite_or,
   input  logic             Arm,
   input  logic [XLEN-1:0]  Trig_PC,
   input  logic             Stop_On_Full,
   input  logic             Rd_En,
   output logic             Rd_Valid,
   output logic [XLEN-1:0]  Rd_PC,
   output logic [XLEN-1:0]  Rd_Data,
   output logic [AW:0]      Count,
   output logic             Full,
   output logic             Empty,
   output logic             Overflow,
   output logic [1:0]       State
);

   localparam int unsigned CW = AW + 1;

   state_e           state_q, state_d;
   logic [XLEN-1:0]  trig_pc_q, trig_pc_d;
   logic             sof_q, sof_d;
   logic             overflow_q, overflow_d;
   logic             trig_hit_c, push_c, push_ok_c, drop_c;
   logic [AW:0]      count_next_c;
   entry_t           push_entry, rd_entry;

   assign push_entry = '{pc: PC_Counter, data: Reg_Write};

   always_comb begin
      trig_hit_c = (PC_Counter == trig_pc_q);
      push_c     = RegWrite_or &&
                   ((state_q == ST_CAPTURE) || ((state_q == ST_ARMED) && trig_hit_c));
      drop_c     = push_c && !push_ok_c;
      state_d    = state_q;
      trig_pc_d  = trig_pc_q;
      sof_d      = sof_q;
      overflow_d = overflow_q;
      case (state_q)
         ST_IDLE: begin
            if (Arm) begin
               state_d   = ST_ARMED;
               trig_pc_d = Trig_PC;
               sof_d     = Stop_On_Full;
            end
         end
         ST_ARMED: begin
            if (trig_hit_c) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: state_d = ST_CAPTURE;
         ST_DONE: begin
            if (Arm) begin
               state_d    = ST_ARMED;
               trig_pc_d  = Trig_PC;
               sof_d      = Stop_On_Full;
               overflow_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (drop_c) overflow_d = 1'b1;
      // Stop-on-full mode ends the capture once the FIFO fills (or a capture had to be dropped).
      if (sof_q && push_c && (drop_c || (count_next_c == CW'(DEPTH)))) state_d = ST_DONE;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= ST_IDLE;
         trig_pc_q  <= '0;
         sof_q      <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         trig_pc_q  <= trig_pc_d;
         sof_q      <= sof_d;
         overflow_q <= overflow_d;
      end
   end

   wb_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk          (Clk),
      .rst_n        (Reset),
      .push         (push_c),
      .push_data    (push_entry),
      .pop_req      (Rd_En),
      .push_ok_c    (push_ok_c),
      .count_next_c (count_next_c),
      .rd_valid     (Rd_Valid),
      .rd_data      (rd_entry),
      .count        (Count),
      .full         (Full),
      .empty        (Empty)
   );

   assign Rd_PC    = rd_entry.pc;
   assign Rd_Data  = rd_entry.data;
   assign Overflow = overflow_q;
   assign State    = state_q;

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

- Captures the datapath's register write-back stream as (PC_Counter, Reg_Write) pairs whenever RegWrite_or is high.
- Captures start from a programmable trigger PC and are buffered in an on-chip FIFO.
- A host or testbench drains the FIFO through a simple read port.
- Sits beside Datapath on its three observation outputs; it is the consumer end of that write-back interface.

## Interface
Parameters:
- DEPTH, 16, FIFO entries (power of two, ≥2)
- AW, 4, log2(DEPTH)

Ports:
- Clk  in  1  rising-edge clock, shared with Datapath
- Reset  in  1  asynchronous, active-low; all state cleared while low
- PC_Counter  in  32  datapath PC of the current instruction
- Reg_Write  in  32  datapath write-back data
- RegWrite_or  in  1  write-back strobe; one capture per high cycle
- Arm  in  1  single-cycle pulse: IDLE→ARMED
- Trig_PC  in  32  PC that starts capture; sampled on Arm
- Stop_On_Full  in  1  1: stop at full; 0: drop and flag; sampled on Arm
- Rd_En  in  1  pop request
- Rd_Valid  out  1  Rd_PC/Rd_Data valid this cycle
- Rd_PC  out  32  popped PC
- Rd_Data  out  32  popped write-back data
- Count  out  AW+1  current occupancy
- Full  out  1  Count==DEPTH
- Empty  out  1  Count==0
- Overflow  out  1  sticky; set on any dropped capture
- State  out  2  FSM state (debug)

## Operation
- FSM states and transitions:
  - IDLE=0: reset state.
    - Arm → ARMED; latch Trig_PC and Stop_On_Full.
  - ARMED=1: wait for the trigger.
    - PC_Counter==Trig_PC and RegWrite_or → CAPTURE; that same write is captured.
    - PC_Counter==Trig_PC without RegWrite_or → CAPTURE; nothing captured that cycle.
  - CAPTURE=2: push {PC_Counter, Reg_Write} on every RegWrite_or cycle.
    - Stop_On_Full=1: a push that makes Count==DEPTH → DONE.
    - Stop_On_Full=0: a push attempted while full and not popping is dropped; Overflow←1; state stays CAPTURE.
  - DONE=3: no pushes; reads continue.
    - Arm → ARMED. Count is preserved; Overflow is cleared.
- Arm in any state other than IDLE/DONE is ignored.
- Push and pop:
  - Push is accepted when !Full, or when Full and a pop occurs in the same cycle.
  - Pop occurs when Rd_En && !Empty. Rd_En while Empty is ignored: no pointer change and no Rd_Valid.
  - Simultaneous accepted push and pop: Count unchanged, both pointers advance.
- Pointers are AW bits wide and wrap modulo DEPTH; Count is tracked separately (AW+1 bits).
- Storage is a DEPTH×64 register array, {PC, data}.

## Timing
- Reset values (asynchronous, while Reset=0):
  - State=IDLE, Count=0, Empty=1, Full=0, Overflow=0, Rd_Valid=0, Rd_PC=0, Rd_Data=0.
  - Pointers 0; latched Trig_PC=0, Stop_On_Full=0.
  - Array contents are don't-care.
- Capture latency: a write at edge N is visible in Count after edge N.
- Earliest pop of that entry: Rd_En in cycle N+1.
- Read latency: 1 cycle. Rd_En accepted at edge K → Rd_Valid=1 with data during cycle K+1. Rd_Valid is low otherwise.
- Back-to-back Rd_En gives Rd_Valid every cycle.
- Full, Empty and Count are registered and reflect the state after the last edge.
- Reset asserted mid-capture or mid-read: immediate return to reset values; a pending Rd_Valid is cancelled.
- Reset deassertion: the first active edge is the first edge with Reset=1.

## Structure
- Shared package wb_trace_pkg:
  - state encoding constants ST_IDLE/ST_ARMED/ST_CAPTURE/ST_DONE
  - entry width constant ENTRY_W=64
- One natural sub-module, wb_trace_fifo: parameterized synchronous FIFO with push/pop/full/empty/count and registered read.
- The top level holds the FSM, trigger latch, and Overflow logic.

## Test plan
- Reset low then high, no Arm, RegWrite_or toggling: State=0, Empty=1, Count=0, no Rd_Valid.
- Arm with Trig_PC=0x0000_0010. Writes at PC 0x0C (data 5), 0x10 (data 7), 0x14 (data 9). Pop twice. Required: Rd_PC/Rd_Data = (0x10,7) then (0x14,9); the 0x0C write is not captured.
- Stop_On_Full=1, DEPTH=16, trigger hit, 20 writes: State=DONE after write 16, Count=16, Overflow=0. The 16 pops return writes 1–16 in order.
- Stop_On_Full=0, 18 writes with no pops: Count=16, Overflow=1, state CAPTURE. Then push and pop in the same cycle while full: Count stays 16 and the new entry is accepted.
- Rd_En with Empty=1: Rd_Valid stays 0 and Count stays 0. Then, mid-capture with Count=5, pulse Reset low for 3 ns: all outputs return to reset values immediately.
- Wrap-around: with Stop_On_Full=0, interleave 40 writes and 40 pops (data = index). The read sequence is 0..39 with no loss, and Overflow=0.
